// File: rtl/mul56_seq_ctrl_if.sv
// mul56_seq_ctrl_if
//   Handshake bundle between an operand producer / result consumer and the
//   sequential 56x56 multiplier controller.
//   Signals:
//     in_valid, a, b   : operand pair offered by the producer
//     in_ready         : controller can take an operand pair this cycle
//     out_valid        : product is available and held stable
//     out_ready        : consumer takes the product this cycle
//     prod             : full 2*MUL_SIZE-bit product a*b
//     prod_hi2         : prod[111:110]
//     prod_mid         : prod[107:54]
//   Modports:
//     master : producer/consumer side (testbench or upstream logic)
//     slave  : controller side
interface mul56_seq_ctrl_if #(
  parameter int MUL_SIZE = 56
);
  logic                    in_valid;
  logic                    in_ready;
  logic [MUL_SIZE-1:0]     a;
  logic [MUL_SIZE-1:0]     b;
  logic                    out_valid;
  logic                    out_ready;
  logic [2*MUL_SIZE-1:0]   prod;
  logic [1:0]              prod_hi2;
  logic [53:0]             prod_mid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod, prod_hi2, prod_mid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod, prod_hi2, prod_mid
  );
endinterface

// File: rtl/mul56_seq_ctrl.sv
// mul56_seq_ctrl
//   Sequential 56x56 unsigned multiplier controller. One operand pair is
//   accepted over a valid/ready handshake. The nine limb partial products
//   (limbs 18/18/20 bits, zero-extended to 20) are computed one per cycle on
//   a single 20x20 multiplier and accumulated, shifted, into a 112-bit
//   result. The product is held stable until the consumer takes it.
//   Latency: accept edge E0 -> out_valid after edge E10.
//   Ports:
//     clk      : clock, rising edge
//     rst      : asynchronous active-high reset
//     i_clear  : synchronous abort back to IDLE (discards any pending result)
//     s_bus    : operand/result handshake (slave side of mul56_seq_ctrl_if)
//     o_busy   : controller is not in IDLE
module mul56_seq_ctrl #(
  parameter int MUL_SIZE = 56
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  mul56_seq_ctrl_if.slave       s_bus,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;

  logic [MUL_SIZE-1:0]     r_a;
  logic [MUL_SIZE-1:0]     r_b;
  logic [39:0]             r_p;
  logic [2:0]              r_sh;     // shift in units of 18 bits (i+j)
  logic                    r_pv;
  logic [2*MUL_SIZE-1:0]   r_acc;

  logic [1:0]              w_i;
  logic [1:0]              w_j;
  logic [19:0]             w_limb_a;
  logic [19:0]             w_limb_b;
  logic [39:0]             w_pp;
  logic [2:0]              w_sh;
  logic [2*MUL_SIZE-1:0]   w_p_shifted;

  // Limb extraction; the top limb is 20 bits wide, the others 18.
  function automatic logic [19:0] limb(input logic [MUL_SIZE-1:0] v,
                                       input logic [1:0] idx);
    logic [19:0] res;
    case (idx)
      2'd0:    res = {2'b00, v[17:0]};
      2'd1:    res = {2'b00, v[35:18]};
      default: res = v[55:36];
    endcase
    return res;
  endfunction

  // Step k -> (i, j) = (k/3, k%3), written as a table to avoid a divider.
  always_comb begin
    w_i = 2'd0;
    w_j = 2'd0;
    case (r_cnt)
      4'd0:    begin w_i = 2'd0; w_j = 2'd0; end
      4'd1:    begin w_i = 2'd0; w_j = 2'd1; end
      4'd2:    begin w_i = 2'd0; w_j = 2'd2; end
      4'd3:    begin w_i = 2'd1; w_j = 2'd0; end
      4'd4:    begin w_i = 2'd1; w_j = 2'd1; end
      4'd5:    begin w_i = 2'd1; w_j = 2'd2; end
      4'd6:    begin w_i = 2'd2; w_j = 2'd0; end
      4'd7:    begin w_i = 2'd2; w_j = 2'd1; end
      4'd8:    begin w_i = 2'd2; w_j = 2'd2; end
      default: begin w_i = 2'd0; w_j = 2'd0; end
    endcase
  end

  assign w_limb_a = limb(r_a, w_i);
  assign w_limb_b = limb(r_b, w_j);
  assign w_sh     = {1'b0, w_i} + {1'b0, w_j};

  // The one shared multiplier: 20x20 unsigned into 40 bits.
  assign w_pp = {20'd0, w_limb_a} * {20'd0, w_limb_b};

  // Align the registered partial product by 18*(i+j) bits.
  always_comb begin
    w_p_shifted = '0;
    case (r_sh)
      3'd0:    w_p_shifted = {72'd0, r_p};
      3'd1:    w_p_shifted = {54'd0, r_p, 18'd0};
      3'd2:    w_p_shifted = {36'd0, r_p, 36'd0};
      3'd3:    w_p_shifted = {18'd0, r_p, 54'd0};
      default: w_p_shifted = {r_p, 72'd0};
    endcase
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_clear) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_bus.in_valid) begin
            r_state    <= ST_MUL;
            r_cnt      <= 4'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_MUL: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd8) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (s_bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand latch, multiplier output register and accumulator.
  // The accumulator trails the multiplier by one cycle (gated by r_pv), so
  // the last partial product lands during DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_p   <= '0;
      r_sh  <= 3'd0;
      r_pv  <= 1'b0;
      r_acc <= '0;
    end else if (i_clear) begin
      // acc is left as is; it is never presented outside DONE.
      r_pv <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_bus.in_valid) begin
            r_a   <= s_bus.a;
            r_b   <= s_bus.b;
            r_acc <= '0;
            r_pv  <= 1'b0;
          end
        end
        ST_MUL: begin
          r_p  <= w_pp;
          r_sh <= w_sh;
          r_pv <= 1'b1;
          if (r_pv) begin
            r_acc <= r_acc + w_p_shifted;
          end
        end
        ST_DRAIN: begin
          r_pv <= 1'b0;
          if (r_pv) begin
            r_acc <= r_acc + w_p_shifted;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_bus.in_ready  = r_in_ready;
  assign s_bus.out_valid = r_out_valid;
  assign s_bus.prod      = r_acc;
  assign s_bus.prod_hi2  = r_acc[111:110];
  assign s_bus.prod_mid  = r_acc[107:54];
  assign o_busy          = r_busy;

endmodule
